nexys_starship_monster_sched: RTL and testbench
===============================================

# nexys_starship_monster_sched

Central monster scheduler for Nexys Starship. It sequences all monster stations (top, bottom, left, right) from one place: it decides when and where a monster spawns, runs each occupied station's deadline, clears stations on player hits, keeps score and declares game over. It replaces per-station free-running FSMs and sits between the game-control/input logic and the display/VGA logic.

## Interface
- NUM_ST, 4: number of stations; power of 2; index 0=top, 1=bottom, 2=left, 3=right.
- SPAWN_TICKS, 3: ticks between spawn attempts; 1..2^CNT_W-1.
- DEADLINE_TICKS, 5: ticks a monster may survive before game over; 1..2^CNT_W-1.
- CNT_W, 4: width of the spawn and deadline counters.

- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a game from INIT or acknowledges OVER.
- tick  in  1  one-cycle game-time enable; all timing counts ticks.
- hit  in  NUM_ST  one-cycle pulse per station: the player defeated that station's monster.
- monster  out  NUM_ST  station occupied.
- score  out  8  monsters defeated in the current game; saturates at 255.
- game_over  out  1  high while in OVER.
- q_Init, q_Play, q_Over  out  1 each  one-hot state flags.

## Operation
- States: INIT, PLAY, OVER (one-hot).
- INIT: monster=0. On start, go to PLAY. On entry to PLAY: score=0, monster=0, spawn_cnt=SPAWN_TICKS, rr_ptr=0.
- PLAY, spawn: each tick decrements spawn_cnt. On a tick with spawn_cnt==1, spawn_cnt reloads and one station is selected. The search runs from the start index upward, modulo NUM_ST, and takes the first station that is empty after this cycle's hits are applied, excluding any station hit this same cycle. The selected station gets monster[i]=1 and dl_cnt[i]=DEADLINE_TICKS, and rr_ptr becomes (sel+1) mod NUM_ST. If every station is full, the spawn is skipped and the counter still reloads.
- PLAY, hit: hit[i] with monster[i]=1 clears monster[i] and increments score (saturating). hit[i] on an empty station is ignored. Several hits in one cycle each count.
- PLAY, deadline: each tick decrements dl_cnt[i] for every occupied station that is not hit this cycle. A tick with dl_cnt[i]==1 and no hit[i] is an expiry.
- Any expiry moves the block to OVER. In OVER, monster and score freeze and further hits, ticks and spawns are ignored.
- OVER: start moves the block to INIT.
- start in PLAY is ignored.

## Timing
- Reset (Reset==0 at a Clk edge) takes effect at that edge, including mid-game. After it: q_Init=1, q_Play=0, q_Over=0, monster=0, score=0, game_over=0, all counters 0, rr_ptr=0, LFSR=8'hA5.
- All outputs are registered. A decision made on the cycle of tick, hit or start is visible one edge later.
- First spawn occurs on the SPAWN_TICKS-th tick after entering PLAY.
- A monster spawned on tick T expires on tick T+DEADLINE_TICKS if it is never hit.
- When hit and expiry land on the same tick, the hit wins: no game over.
- tick and start together in INIT: start is taken, and the tick is not counted.

## Configuration
- STARSHIP_LFSR_EN defined: an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) advances every Clk cycle in PLAY. The spawn search starts at lfsr[log2(NUM_ST)-1:0], and rr_ptr is unused.
- Not defined: the spawn search starts at rr_ptr (deterministic round-robin), and no LFSR is present.

## Structure
- Package nexys_starship_pkg holds the state one-hot localparams, station index constants, and the LFSR seed and taps.
- One sub-module, nexys_starship_station_timer, is instantiated NUM_ST times. Each instance owns monster[i] and dl_cnt[i], takes load, hit, tick and enable, and outputs occupied and expire.
- The top level holds the FSM, spawn counter, selector, score and LFSR.

## Test plan
Defaults apply, STARSHIP_LFSR_EN off.
- Reset low during PLAY with monster=4'b0011 → next edge: q_Init=1, monster=0, score=0.
- start, then 3 ticks → monster=4'b0001; 3 more ticks with hit[0] pulsed after tick 4 → monster=4'b0010, score=1.
- start, then 8 ticks with no hits → station 0 expires on tick 8: game_over=1, q_Over=1, monster=4'b0011 frozen. start → q_Init=1.
- hit[0] on the same cycle as the tick-8 expiry → no game over, monster[0]=0, score=1.
- Hit each station as it spawns, for 260 spawns → score saturates at 255.
- Fill all 4 stations by keeping hits just ahead of the deadlines → the spawn on the next spawn tick is skipped, monster stays 4'b1111, and spawn_cnt reloads.

Source files
------------

// File: rtl/nexys_starship_pkg.sv
// nexys_starship_pkg: shared state encoding, station indices and LFSR constants for the monster scheduler
package nexys_starship_pkg;
  typedef enum logic [2:0] {S_INIT = 3'b001, S_PLAY = 3'b010, S_OVER = 3'b100} state_t;
  localparam int STN_TOP = 0;
  localparam int STN_BOTTOM = 1;
  localparam int STN_LEFT = 2;
  localparam int STN_RIGHT = 3;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/nexys_starship_station_timer.sv
// nexys_starship_station_timer: occupancy flag and deadline counter for one monster station
module nexys_starship_station_timer #(
  parameter int DEADLINE_TICKS = 5,
  parameter int CNT_W = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  input  logic load,
  input  logic hit,
  input  logic tick,
  output logic occupied,
  output logic expire
);
  logic [CNT_W-1:0] dl_cnt;
  assign expire = enable & tick & occupied & ~hit & (dl_cnt == CNT_W'(1));
  always_ff @(posedge Clk)
    if (!Reset || clear) begin
      occupied <= 1'b0;
      dl_cnt <= '0;
    end else if (enable) begin
      if (load) begin
        occupied <= 1'b1;
        dl_cnt <= CNT_W'(DEADLINE_TICKS);
      end else if (hit && occupied) begin
        occupied <= 1'b0;
        dl_cnt <= '0;
      end else if (tick && occupied)
        dl_cnt <= dl_cnt - 1'b1;
    end
endmodule

// File: rtl/nexys_starship_monster_sched.sv
// nexys_starship_monster_sched: central spawn/deadline/score scheduler for all monster stations
// STARSHIP_LFSR_EN selects an LFSR-randomised spawn search start instead of round-robin.
module nexys_starship_monster_sched
  import nexys_starship_pkg::*;
#(
  parameter int NUM_ST = 4,
  parameter int SPAWN_TICKS = 3,
  parameter int DEADLINE_TICKS = 5,
  parameter int CNT_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              tick,
  input  logic [NUM_ST-1:0] hit,
  output logic [NUM_ST-1:0] monster,
  output logic [7:0]        score,
  output logic              game_over,
  output logic              q_Init,
  output logic              q_Play,
  output logic              q_Over
);
  localparam int IW = $clog2(NUM_ST);
  state_t st;
  logic [CNT_W-1:0] spawn_cnt;
  logic [IW-1:0] base, sel;
  logic found, spawn_now;
  logic [NUM_ST-1:0] free, load, expire;
  logic [8:0] score_sum;
`ifdef STARSHIP_LFSR_EN
  logic [7:0] lfsr;
  assign base = lfsr[IW-1:0];
  always_ff @(posedge Clk)
    if (!Reset) lfsr <= LFSR_SEED;
    else if (st == S_PLAY) lfsr <= lfsr_next(lfsr);
`else
  logic [IW-1:0] rr_ptr;
  assign base = rr_ptr;
  always_ff @(posedge Clk)
    if (!Reset) rr_ptr <= '0;
    else if (st == S_INIT && start) rr_ptr <= '0;
    else if (spawn_now && found) rr_ptr <= sel + 1'b1;
`endif
  assign {q_Over, q_Play, q_Init} = st;
  assign game_over = st[2];
  // a station hit this cycle is not eligible for the spawn, even though it ends up empty
  assign free = ~monster & ~hit;
  assign spawn_now = (st == S_PLAY) & tick & (spawn_cnt == CNT_W'(1));
  assign load = (spawn_now && found) ? NUM_ST'(1) << sel : '0;
  assign score_sum = {1'b0, score} + 9'($countones(hit & monster));
  always_comb begin
    found = 1'b0;
    sel = base;
    for (int k = 0; k < NUM_ST; k++)
      if (!found && free[base + IW'(k)]) begin
        found = 1'b1;
        sel = base + IW'(k);
      end
  end
  for (genvar i = 0; i < NUM_ST; i++) begin : g_st
    nexys_starship_station_timer #(.DEADLINE_TICKS(DEADLINE_TICKS), .CNT_W(CNT_W)) u_timer (
      .Clk(Clk),
      .Reset(Reset),
      .clear(start && st != S_PLAY),
      .enable(st == S_PLAY),
      .load(load[i]),
      .hit(hit[i]),
      .tick(tick),
      .occupied(monster[i]),
      .expire(expire[i])
    );
  end
  always_ff @(posedge Clk)
    if (!Reset) begin
      st <= S_INIT;
      spawn_cnt <= '0;
      score <= '0;
    end else if (st == S_INIT && start) begin
      st <= S_PLAY;
      spawn_cnt <= CNT_W'(SPAWN_TICKS);
      score <= '0;
    end else if (st == S_PLAY) begin
      score <= score_sum[8] ? 8'hFF : score_sum[7:0];
      if (tick) spawn_cnt <= spawn_now ? CNT_W'(SPAWN_TICKS) : spawn_cnt - 1'b1;
      if (|expire) st <= S_OVER;
    end else if (st == S_OVER && start)
      st <= S_INIT;
endmodule

// File: tb/tb_nexys_starship_monster_sched.sv
// tb_nexys_starship_monster_sched: vector table, corner-case sequences and randomized run against a tick-time reference model
module tb_nexys_starship_monster_sched;
  localparam int SP = 3;
  localparam int DL = 5;
  logic Clk = 0, Reset = 0, start = 0, tick = 0;
  logic [3:0] hit = 0;
  logic [3:0] monster, monster2;
  logic [7:0] score, score2;
  logic game_over, q_Init, q_Play, q_Over;
  logic go2, qi2, qp2, qo2;
  int checks = 0, errors = 0;
  int m_state, m_n, m_rr, m_score;
  logic [3:0] m_occ;
  int m_born[4];
  typedef struct {
    logic s;
    logic t;
    logic [3:0] h;
    logic [3:0] mon;
    logic [7:0] sc;
    logic [2:0] fl;
  } vec_t;
  vec_t tv[11];

  nexys_starship_monster_sched dut (
    .Clk(Clk), .Reset(Reset), .start(start), .tick(tick), .hit(hit),
    .monster(monster), .score(score), .game_over(game_over),
    .q_Init(q_Init), .q_Play(q_Play), .q_Over(q_Over)
  );
  nexys_starship_monster_sched #(.NUM_ST(4), .SPAWN_TICKS(3), .DEADLINE_TICKS(14), .CNT_W(4)) dut2 (
    .Clk(Clk), .Reset(Reset), .start(start), .tick(tick), .hit(hit),
    .monster(monster2), .score(score2), .game_over(go2),
    .q_Init(qi2), .q_Play(qp2), .q_Over(qo2)
  );

  always #5 Clk = ~Clk;

  function automatic logic [2:0] exp_flags();
    return m_state == 0 ? 3'b001 : m_state == 1 ? 3'b010 : 3'b100;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_n = 0; m_rr = 0; m_score = 0; m_occ = 0;
  endfunction

  // game time is the absolute tick number since PLAY began; spawns fall on multiples of SP
  function automatic void model_step(logic s, logic t, logic [3:0] h);
    logic [3:0] pre;
    bit ex, done;
    if (m_state == 0) begin
      if (s) begin m_state = 1; m_score = 0; m_occ = 0; m_n = 0; m_rr = 0; end
    end else if (m_state == 1) begin
      pre = m_occ; ex = 0; done = 0;
      for (int i = 0; i < 4; i++)
        if (h[i] && pre[i]) begin
          m_occ[i] = 0;
          m_score = m_score == 255 ? 255 : m_score + 1;
        end
      if (t) begin
        m_n++;
        for (int i = 0; i < 4; i++)
          if (pre[i] && !h[i] && m_born[i] + DL == m_n) ex = 1;
        if (m_n % SP == 0)
          for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_rr + k) % 4;
            if (!done && !pre[j] && !h[j]) begin
              done = 1; m_occ[j] = 1; m_born[j] = m_n; m_rr = (j + 1) % 4;
            end
          end
      end
      if (ex) m_state = 2;
    end else if (s) begin
      m_state = 0; m_occ = 0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic t, input logic [3:0] h);
    start = s; tick = t; hit = h;
    @(posedge Clk); #1;
    model_step(s, t, h);
    start = 0; tick = 0; hit = 0;
  endtask

  task automatic do_reset();
    Reset = 0;
    @(posedge Clk); #1;
    Reset = 1;
    model_reset();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 4'b0);
  endtask

  initial begin
    logic [31:0] r;
    int spawns, guard;
    tv[0]  = '{1, 0, 4'b0000, 4'b0000, 8'd0, 3'b010};
    tv[1]  = '{0, 1, 4'b0000, 4'b0000, 8'd0, 3'b010};
    tv[2]  = '{0, 1, 4'b0000, 4'b0000, 8'd0, 3'b010};
    tv[3]  = '{0, 1, 4'b0000, 4'b0001, 8'd0, 3'b010};
    tv[4]  = '{0, 1, 4'b0000, 4'b0001, 8'd0, 3'b010};
    tv[5]  = '{0, 0, 4'b0001, 4'b0000, 8'd1, 3'b010};
    tv[6]  = '{0, 1, 4'b0000, 4'b0000, 8'd1, 3'b010};
    tv[7]  = '{0, 1, 4'b0000, 4'b0010, 8'd1, 3'b010};
    tv[8]  = '{1, 0, 4'b0000, 4'b0010, 8'd1, 3'b010};
    tv[9]  = '{0, 0, 4'b1000, 4'b0010, 8'd1, 3'b010};
    tv[10] = '{0, 1, 4'b0010, 4'b0000, 8'd2, 3'b010};
    Reset = 0;
    repeat (2) @(posedge Clk);
    #1;
    do_reset();
    check("reset_state", {game_over, q_Over, q_Play, q_Init, monster, score}, {4'b0001, 4'b0, 8'd0});
    for (int v = 0; v < 11; v++) begin
      step(tv[v].s, tv[v].t, tv[v].h);
      check($sformatf("vec%0d", v), {q_Over, q_Play, q_Init, monster, score}, {tv[v].fl, tv[v].mon, tv[v].sc});
    end

    do_reset();
    step(1, 0, 0);
    ticks(6);
    check("midgame_monster", monster, 4'b0011);
    do_reset();
    check("midgame_reset", {q_Init, q_Play, monster, score}, {2'b10, 4'b0, 8'd0});

    step(1, 1, 0);
    check("start_tick_init", {q_Play, monster}, {1'b1, 4'b0});
    ticks(2);
    check("tick_not_counted", monster, 4'b0000);
    ticks(1);
    check("first_spawn", monster, 4'b0001);

    do_reset();
    step(1, 0, 0);
    ticks(7);
    check("pre_expiry", {game_over, monster}, {1'b0, 4'b0011});
    ticks(1);
    check("expiry", {game_over, q_Over, monster, score}, {2'b11, 4'b0011, 8'd0});
    step(0, 1, 4'b0011);
    check("over_frozen", {game_over, monster, score}, {1'b1, 4'b0011, 8'd0});
    step(1, 0, 0);
    check("over_to_init", {q_Init, q_Over, monster}, {2'b10, 4'b0});

    do_reset();
    step(1, 0, 0);
    ticks(7);
    step(0, 1, 4'b0001);
    check("hit_beats_expiry", {game_over, q_Play, monster, score}, {2'b01, 4'b0010, 8'd1});

    do_reset();
    step(1, 0, 0);
    spawns = 0; guard = 0;
    while (spawns < 260 && guard < 5000) begin
      guard++;
      if (monster != 0) step(0, 0, monster);
      else begin
        step(0, 1, 0);
        if (monster != 0) spawns++;
      end
    end
    check("sat_spawns", spawns, 260);
    check("sat_score", {q_Play, score}, {1'b1, 8'd255});

    do_reset();
    step(1, 0, 0);
    ticks(12);
    check("full_fill", monster2, 4'b1111);
    ticks(3);
    check("full_skip", {go2, monster2}, {1'b0, 4'b1111});
    step(0, 0, 4'b0001);
    check("full_hit", {monster2, score2}, {4'b1110, 8'd1});
    ticks(2);
    check("full_reload", {go2, monster2}, {1'b0, 4'b1110});
    ticks(1);
    check("full_respawn", {go2, monster2}, {1'b0, 4'b1111});

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r = $urandom;
      if (r % 300 == 0) do_reset();
      else step(r[4:0] == 0 || (m_state != 1 && r[7:6] == 0), r[5], r[9:8] == 0 ? r[13:10] : 4'b0);
      check("random", {q_Over, q_Play, q_Init, monster, score}, {exp_flags(), m_occ, m_score[7:0]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
